// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio capture/playback path.
package audio_pkg;

   // Write-side FSM of the USB-to-flash packer
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_WAIT  = 2'd2
   } packer_state_t;

   localparam int unsigned PACKER_DEPTH = 8;
   localparam int unsigned PACKER_GUARD = 2;
   localparam int unsigned FLASH_ADDR_W = 23;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered pointers.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   // Qualify requests; a push into a full FIFO is legal only alongside a pop
   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because the pointers gate validity
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/usb_flash_packer.sv
// Packs USB bytes into big-endian 16-bit words and paces flash write requests.
module usb_flash_packer
   import audio_pkg::*;
#(
   parameter int unsigned DEPTH = PACKER_DEPTH,
   parameter int unsigned GUARD = PACKER_GUARD
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   input  logic                    flush,
   output logic                    hold,
   input  logic                    busy,
   output logic [15:0]             wdata,
   output logic                    dowrite,
   output logic [FLASH_ADDR_W-1:0] words_written,
   output logic                    pending,
   output logic                    overflow,
   output logic                    idle
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

   logic                    pending_q, pending_d;
   logic [7:0]              held_q, held_d;
   logic                    overflow_q, overflow_d;

   logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [15:0]             fifo_push_data, fifo_head;
   logic [CW-1:0]           fifo_count;

   packer_state_t           state_q;
   logic [GW-1:0]           guard_q;
   logic                    dowrite_q;
   logic [15:0]             wdata_q;
   logic [FLASH_ADDR_W-1:0] words_q;

   sync_fifo #(
      .WIDTH (16),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Pair register and drop logic: byte first, then flush acts on the result
   always_comb begin
      fifo_pop       = (state_q == ST_IDLE) & ~fifo_empty & ~busy;
      pending_d      = pending_q;
      held_d         = held_q;
      overflow_d     = overflow_q;
      fifo_push      = 1'b0;
      fifo_push_data = 16'h0000;
      if (enable & in_valid) begin
         if (pending_q) begin
            if (~fifo_full | fifo_pop) begin
               fifo_push      = 1'b1;
               fifo_push_data = {held_q, in_data};
               pending_d      = 1'b0;
            end else begin
               overflow_d = 1'b1;
            end
         end else begin
            held_d    = in_data;
            pending_d = 1'b1;
         end
      end
      // A completed pair leaves pending_d clear, so at most one push occurs
      if (flush & pending_d) begin
         if (~fifo_full | fifo_pop) begin
            fifo_push      = 1'b1;
            fifo_push_data = {held_d, 8'h00};
         end else begin
            overflow_d = 1'b1;
         end
         pending_d = 1'b0;
      end
   end

   // Pair register and sticky overflow flag
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q  <= 1'b0;
         held_q     <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         held_q     <= held_d;
         overflow_q <= overflow_d;
      end
   end

   // Write pacing FSM: issue, ignore busy for the guard window, then wait for not-busy
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         guard_q   <= '0;
         dowrite_q <= 1'b0;
         wdata_q   <= 16'h0000;
         words_q   <= '0;
      end else begin
         dowrite_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  wdata_q   <= fifo_head;
                  dowrite_q <= 1'b1;
                  words_q   <= words_q + FLASH_ADDR_W'(1);
                  guard_q   <= GW'(GUARD);
                  state_q   <= ST_GUARD;
               end
            end
            ST_GUARD: begin
               if (guard_q <= GW'(1)) begin
                  guard_q <= '0;
                  state_q <= ST_WAIT;
               end else begin
                  guard_q <= guard_q - GW'(1);
               end
            end
            ST_WAIT: begin
               if (~busy) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Back-pressure and status derived from registered state
   always_comb begin
      hold = (fifo_count >= CW'(DEPTH - 2)) |
             ((fifo_count == CW'(DEPTH - 1)) & pending_q);
      idle = fifo_empty & (state_q == ST_IDLE) & ~pending_q & ~busy;
   end

   assign wdata         = wdata_q;
   assign dowrite       = dowrite_q;
   assign words_written = words_q;
   assign pending       = pending_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_usb_flash_packer.sv
// Self-checking bench for usb_flash_packer with a queue-based reference model.
module tb_usb_flash_packer;

   logic        clock = 1'b0;
   logic        reset, enable, in_valid, flush, busy;
   logic [7:0]  in_data;
   logic        hold, dowrite, pending, overflow, idle;
   logic [15:0] wdata;
   logic [22:0] words_written;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Observed writes and the reference model
   logic [15:0] obs_w[$];
   int          obs_t[$];
   logic [15:0] exp_q[$];
   bit          mdl_pending;
   logic [7:0]  mdl_held;
   int          mdl_total;

   usb_flash_packer #(.DEPTH(8), .GUARD(2)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .flush         (flush),
      .hold          (hold),
      .busy          (busy),
      .wdata         (wdata),
      .dowrite       (dowrite),
      .words_written (words_written),
      .pending       (pending),
      .overflow      (overflow),
      .idle          (idle)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (dowrite === 1'b1) begin
         obs_w.push_back(wdata);
         obs_t.push_back(cyc);
         $display("write #%0d wdata=%h cycle=%0d", obs_w.size(), wdata, cyc);
      end
   endtask

   // Byte semantics: pair first, then optional flush pads an odd byte
   task automatic model_byte(input logic [7:0] b, input bit f);
      if (mdl_pending) begin
         exp_q.push_back({mdl_held, b});
         mdl_total++;
         mdl_pending = 0;
      end else begin
         mdl_held    = b;
         mdl_pending = 1;
      end
      if (f && mdl_pending) begin
         exp_q.push_back({mdl_held, 8'h00});
         mdl_total++;
         mdl_pending = 0;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit f);
      in_valid = 1'b1;
      in_data  = b;
      flush    = f;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      if (enable) model_byte(b, f);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
      if (mdl_pending) begin
         exp_q.push_back({mdl_held, 8'h00});
         mdl_total++;
         mdl_pending = 0;
      end
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (obs_w.size() < n && k < budget) begin
         step();
         k++;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (idle !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      obs_w.delete();
      obs_t.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; in_valid = 1'b0; flush = 1'b0;
      busy = 1'b0; in_data = 8'h00;
      step(); step(); step();
      reset = 1'b0;
      mdl_pending = 0; mdl_held = 8'h00; mdl_total = 0;
      exp_q.delete(); obs_w.delete(); obs_t.delete();
      n_checks++; if (hold !== 1'b0) $display("FAIL reset_hold got=%b exp=0", hold); else n_pass++;
      n_checks++; if (dowrite !== 1'b0) $display("FAIL reset_dowrite got=%b exp=0", dowrite); else n_pass++;
      n_checks++; if (pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", pending); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (words_written !== 23'd0) $display("FAIL reset_words got=%0d exp=0", words_written); else n_pass++;
      n_checks++; if (wdata !== 16'h0000) $display("FAIL reset_wdata got=%h exp=0000", wdata); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else n_pass++;
   endtask

   task automatic test_basic_pair();
      int e;
      wait_idle();
      send(8'hA1, 0);
      send(8'hB2, 0);
      e = cyc;
      wait_writes(1, 20);
      step();
      n_checks++; if (obs_w.size() != 1) $display("FAIL basic_count got=%0d exp=1", obs_w.size()); else n_pass++;
      if (obs_w.size() >= 1) begin
         n_checks++; if (obs_w[0] !== exp_q[0]) $display("FAIL basic_wdata got=%h exp=%h", obs_w[0], exp_q[0]); else n_pass++;
         n_checks++; if (obs_t[0] != e + 1) $display("FAIL basic_latency got=%0d exp=%0d", obs_t[0], e + 1); else n_pass++;
      end
      n_checks++; if (words_written !== 23'(mdl_total)) $display("FAIL basic_words got=%0d exp=%0d", words_written, mdl_total); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_flush();
      wait_idle();
      send(8'h7F, 0);
      n_checks++; if (pending !== 1'b1) $display("FAIL flush_pending_set got=%b exp=1", pending); else n_pass++;
      do_flush();
      n_checks++; if (pending !== 1'b0) $display("FAIL flush_pending_clr got=%b exp=0", pending); else n_pass++;
      send(8'h33, 1);
      n_checks++; if (pending !== 1'b0) $display("FAIL flush_same_pending got=%b exp=0", pending); else n_pass++;
      wait_writes(2, 40);
      repeat (10) step();
      n_checks++; if (obs_w.size() != exp_q.size()) $display("FAIL flush_count got=%0d exp=%0d", obs_w.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < obs_w.size() && i < exp_q.size(); i++) begin
         n_checks++; if (obs_w[i] !== exp_q[i]) $display("FAIL flush_wdata[%0d] got=%h exp=%h", i, obs_w[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if (words_written !== 23'(mdl_total)) $display("FAIL flush_words got=%0d exp=%0d", words_written, mdl_total); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_hold_stream();
      bit prev_hold = 0, cur_hold, rose = 0, busy_phase = 1, exp_hold;
      int sent = 0, k = 0, after = 0, n;
      wait_idle();
      busy = 1'b1;
      while (sent < 20 && k < 600) begin
         if (busy_phase) begin
            exp_hold = (exp_q.size() >= 6) || (exp_q.size() == 7 && mdl_pending);
            n_checks++; if (hold !== exp_hold) $display("FAIL hold_level got=%b exp=%b words=%0d", hold, exp_hold, exp_q.size()); else n_pass++;
            if (hold === 1'b1 && !rose) begin
               rose = 1;
               n_checks++; if (exp_q.size() != 6) $display("FAIL hold_rise_count got=%0d exp=6", exp_q.size()); else n_pass++;
            end
            if (rose) after++;
            if (after > 6) begin busy = 1'b0; busy_phase = 0; end
         end
         cur_hold = hold;
         if (!prev_hold) begin send(8'($urandom), 0); sent++; end
         else step();
         prev_hold = cur_hold;
         k++;
      end
      busy = 1'b0;
      n_checks++; if (rose != 1) $display("FAIL hold_never_rose got=0 exp=1"); else n_pass++;
      n = exp_q.size();
      wait_writes(n, 200);
      n_checks++; if (overflow !== 1'b0) $display("FAIL hold_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (obs_w.size() != 10) $display("FAIL hold_writes got=%0d exp=10", obs_w.size()); else n_pass++;
      for (int i = 0; i < obs_w.size() && i < n; i++) begin
         n_checks++; if (obs_w[i] !== exp_q[i]) $display("FAIL hold_wdata[%0d] got=%h exp=%h", i, obs_w[i], exp_q[i]); else n_pass++;
         if (i > 0) begin
            n_checks++; if (obs_t[i] - obs_t[i-1] < 4) $display("FAIL hold_spacing[%0d] got=%0d exp>=4", i, obs_t[i] - obs_t[i-1]); else n_pass++;
         end
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      bit prev_hold = 0, cur_hold;
      int sent = 0, k = 0, n;
      wait_idle();
      while (sent < 60 && k < 1500) begin
         busy = ($urandom_range(9) < 3);
         cur_hold = hold;
         if (!prev_hold && $urandom_range(1) == 1) begin
            send(8'($urandom), $urandom_range(9) == 0);
            sent++;
         end else if (!prev_hold && $urandom_range(14) == 0) begin
            do_flush();
         end else begin
            step();
         end
         prev_hold = cur_hold;
         k++;
      end
      busy = 1'b0;
      if (!hold) do_flush();
      n = exp_q.size();
      wait_writes(n, n * 10 + 50);
      n_checks++; if (obs_w.size() != n) $display("FAIL rand_writes got=%0d exp=%0d", obs_w.size(), n); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rand_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (pending !== 1'b0) $display("FAIL rand_pending got=%b exp=0", pending); else n_pass++;
      for (int i = 0; i < obs_w.size() && i < n; i++) begin
         n_checks++; if (obs_w[i] !== exp_q[i]) $display("FAIL rand_wdata[%0d] got=%h exp=%h", i, obs_w[i], exp_q[i]); else n_pass++;
         if (i > 0) begin
            n_checks++; if (obs_t[i] - obs_t[i-1] < 4) $display("FAIL rand_spacing[%0d] got=%0d exp>=4", i, obs_t[i] - obs_t[i-1]); else n_pass++;
         end
      end
      step();
      n_checks++; if (words_written !== 23'(mdl_total)) $display("FAIL rand_words got=%0d exp=%0d", words_written, mdl_total); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_overflow();
      int n;
      wait_idle();
      busy = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         in_valid = 1'b1; in_data = 8'(i);
         step();
         in_valid = 1'b0;
         if (i <= 17) model_byte(8'(i), 0);  // byte 18 finds the FIFO full
      end
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow); else n_pass++;
      n_checks++; if (pending !== 1'b1) $display("FAIL ovf_pending got=%b exp=1", pending); else n_pass++;
      n_checks++; if (obs_w.size() != 0) $display("FAIL ovf_early_write got=%0d exp=0", obs_w.size()); else n_pass++;
      busy = 1'b0;
      wait_writes(8, 100);
      do_flush();
      n = exp_q.size();
      wait_writes(n, 60);
      repeat (10) step();
      n_checks++; if (obs_w.size() != 9) $display("FAIL ovf_writes got=%0d exp=9", obs_w.size()); else n_pass++;
      for (int i = 0; i < obs_w.size() && i < n; i++) begin
         n_checks++; if (obs_w[i] !== exp_q[i]) $display("FAIL ovf_wdata[%0d] got=%h exp=%h", i, obs_w[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_enable();
      wait_idle();
      busy = 1'b1;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      enable = 1'b0;
      send(8'h55, 0); send(8'h66, 0); send(8'h77, 0);
      n_checks++; if (pending !== 1'b0) $display("FAIL en_pending got=%b exp=0", pending); else n_pass++;
      busy = 1'b0;
      wait_writes(2, 40);
      repeat (20) step();
      n_checks++; if (obs_w.size() != 2) $display("FAIL en_writes got=%0d exp=2", obs_w.size()); else n_pass++;
      for (int i = 0; i < obs_w.size() && i < exp_q.size(); i++) begin
         n_checks++; if (obs_w[i] !== exp_q[i]) $display("FAIL en_wdata[%0d] got=%h exp=%h", i, obs_w[i], exp_q[i]); else n_pass++;
      end
      enable = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      wait_idle();
      send(8'hC0, 0); send(8'hDE, 0);
      wait_writes(1, 20);
      busy = 1'b1;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
      send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
      n_checks++; if (obs_w.size() < 1 || obs_w[0] !== 16'hC0DE) $display("FAIL mid_first_write got=%0d words exp=C0DE", obs_w.size()); else n_pass++;
      reset = 1'b1; busy = 1'b0;
      step();
      reset = 1'b0;
      obs_w.delete(); obs_t.delete(); exp_q.delete();
      mdl_pending = 0; mdl_total = 0;
      n_checks++; if (idle !== 1'b1) $display("FAIL mid_idle got=%b exp=1", idle); else n_pass++;
      n_checks++; if (words_written !== 23'd0) $display("FAIL mid_words got=%0d exp=0", words_written); else n_pass++;
      n_checks++; if (dowrite !== 1'b0) $display("FAIL mid_dowrite got=%b exp=0", dowrite); else n_pass++;
      repeat (20) step();
      n_checks++; if (obs_w.size() != 0) $display("FAIL mid_no_writes got=%0d exp=0", obs_w.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_pair();
      test_flush();
      test_hold_stream();
      test_random();
      test_overflow();
      test_reset();
      test_enable();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_flash_packer.md
# usb_flash_packer

Packs the byte stream from `usb_input` into 16-bit words and issues paced write requests to `flash_manager`. It sits between the USB FIFO receiver and the flash write port, and feeds the `out`/`newout` path into `wdata`/`dowrite`. The first byte of each pair goes in the high byte, which matches playback reading samples from `frdata[15:8]`. A small word FIFO absorbs flash busy periods, and back-pressure reaches the USB receiver through `hold`.

## Interface
- `DEPTH`, 8: word FIFO depth; power of two, ≥4.
- `GUARD`, 2: cycles after a `dowrite` pulse during which `busy` is ignored, so that `flash_manager` has time to raise it.
- `clock`  in  1  system clock (27 MHz).
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `enable`  in  1  1 = accept bytes (write mode); 0 = ignore `in_valid`. Draining continues when `enable` is 0.
- `in_data`  in  8  byte from `usb_input.out`.
- `in_valid`  in  1  one-cycle strobe from `usb_input.newout`.
- `flush`  in  1  one-cycle strobe; pads a pending odd byte with 8'h00 and pushes it.
- `hold`  out  1  to `usb_input.hold`; requests that the USB stream stop.
- `busy`  in  1  from `flash_manager.busy`.
- `wdata`  out  16  to `flash_manager.wdata`.
- `dowrite`  out  1  to `flash_manager.dowrite`; one-cycle pulse.
- `words_written`  out  23  count of `dowrite` pulses.
- `pending`  out  1  an odd byte is held in the pair register.
- `overflow`  out  1  sticky; a byte was dropped.
- `idle`  out  1  FIFO is empty, the FSM is in IDLE, `pending` is 0 and `busy` is 0.

## Operation
- Pair register: the first accepted byte is latched and `pending` is set. The second accepted byte pushes `{first, second}` and clears `pending`.
- Accept condition: `enable & in_valid`, and no drop is required.
- Drop condition: the byte would complete a word while the FIFO is full, and no pop occurs in the same cycle.
  - The dropped byte is discarded, `overflow` is set, and `pending` is unchanged.
- `flush` while `pending` is set pushes `{held, 8'h00}`. If the FIFO is full, the pad is dropped, `overflow` is set and `pending` is cleared.
- `in_valid` and `flush` in the same cycle: the byte is processed first, then `flush` acts on the resulting `pending`.
  - A completed pair is never padded.
  - A new odd byte is padded; this is a single push.
- `hold` = 1 when FIFO count ≥ DEPTH−2, or when count = DEPTH−1 and `pending` is set. This leaves slack for bytes already in flight.
- Simultaneous FIFO push and pop are legal; count is unchanged.
- Write FSM states:
  - IDLE: when the FIFO is non-empty and `busy` = 0, register `wdata` ← head, set `dowrite` = 1, pop, load the guard counter with GUARD, and go to GUARD.
  - GUARD: `dowrite` returns to 0. Decrement the counter; at 0, go to WAIT.
  - WAIT: when `busy` = 0, go to IDLE.
- `words_written` increments on each `dowrite` pulse and wraps modulo 2^23.
- Reset values:
  - `hold`, `dowrite`, `pending`, `overflow` and `words_written` are 0.
  - `wdata` is 16'h0000.
  - `idle` is 1 (it is combinational).
  - FIFO is empty and the FSM is in IDLE.
- Reset mid-operation discards the FIFO contents and the pending byte. If a `dowrite` pulse is in flight, it is cut off on the reset cycle.

## Timing
- Second byte strobed in cycle t: the word is in the FIFO after edge t+1.
- With `busy` = 0, `dowrite` is high in cycle t+2. Minimum byte-pair-to-write latency is 2 cycles.
- Back-to-back writes are spaced by at least GUARD+2 cycles. Any `busy` time beyond the guard window extends WAIT.
- `hold` is combinational from registered count and `pending`, with no extra latency.
- `wdata` is stable from the `dowrite` cycle until the next pop.

## Structure
- Shared package `audio_pkg` holds:
  - the `packer_state_t` enum (IDLE, GUARD, WAIT);
  - the defaults `PACKER_DEPTH` = 8 and `PACKER_GUARD` = 2;
  - `FLASH_ADDR_W` = 23.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH): push, pop, head, count, full and empty, with registered pointers and a first-word-fall-through head.
- The pair register, the drop/flush logic and the FSM live in the top level.

## Test plan
- Reset, then bytes 8'hA1 and 8'hB2 with `busy` = 0 → one `dowrite` with `wdata` = 16'hA1B2 two cycles after B2; `words_written` = 1.
- Byte 8'h7F, then `flush` → `wdata` = 16'h7F00 and `pending` = 0. Byte 8'h33 with `flush` in the same cycle → 16'h3300 as a single push.
- Hold `busy` = 1 and stream 20 bytes while honouring `hold` with a 1-cycle lag → `hold` rises at count 6 and no `overflow`. Release `busy` → 10 writes in order, spaced ≥4 cycles apart.
- Hold `busy` = 1 and ignore `hold` for 18 bytes → the first 16 bytes are stored, a later pair-completing byte is dropped, `overflow` = 1 and stays 1 until `reset`.
- `enable` = 0 with `in_valid` strobes → no pushes and `pending` = 0. Words already queued still drain.
- Assert `reset` during WAIT with 3 words queued → the next cycle shows `idle` = 1, `words_written` = 0 and no further `dowrite`.
